adder5: RTL and testbench

- Registered unsigned adder: two WIDTH-bit operands (default 5) in, full-precision (WIDTH+1)-bit sum out, carry never lost.
- One pipeline register stage with a valid flag alongside the data.
- Serves as the arithmetic leaf cell in the seminar datapath; its exhaustive bench prints every a+b pair as "aaa+bbb=sss" (3-digit decimal).
- Sum formed by an explicit ripple chain of full-adder cells (generate loop), not an inferred "+", so the cell structure remains inspectable.

---
 rtl/adder5.sv | 68 ++++++
 tb/tb_adder5.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adder5.sv
// adder5: registered unsigned adder built from an explicit ripple chain of
// full-adder cells. Result is WIDTH+1 bits wide so the carry-out is never lost.
// One pipeline stage; out_valid tracks in_valid with one cycle of latency.

// Single-bit full adder. Kept as its own cell so the netlist shows the chain.
module adder5_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule

module adder5 #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   out,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Ripple chain: cell i consumes c[i] and hands c[i+1] to the next cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        adder5_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Output register: capture only qualified operands; idle cycles hold out
    // so don't-care inputs never disturb the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= {c[WIDTH], s};
            end
        end
    end

endmodule

// File: tb/tb_adder5.sv
// Self-checking bench for adder5: reset behaviour, corner sums, carry-in,
// exhaustive 5-bit sweep, valid gaps, random traffic, and WIDTH=8 / WIDTH=1.
module tb_adder5;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [4:0] a;
    logic [4:0] b;
    logic       cin;
    logic [5:0] out;
    logic       out_valid;

    logic       in_valid8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic [8:0] out8;
    logic       out_valid8;

    logic       in_valid1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic [1:0] out1;
    logic       out_valid1;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int exp_out   = 0;
    int exp_valid = 0;

    adder5 #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out(out), .out_valid(out_valid)
    );

    adder5 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8), .cin(cin8),
        .out(out8), .out_valid(out_valid8)
    );

    adder5 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
        .out(out1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of traffic on the WIDTH=5 instance; model follows the
    // behavioural rules: valid edge loads a+b+cin, idle edge holds out.
    task automatic step(input int ta, input int tb_, input int tc, input int tv,
                        input string tag);
        a        = 5'(ta);
        b        = 5'(tb_);
        cin      = tc[0];
        in_valid = tv[0];
        @(posedge clk);
        #1;
        if (tv != 0) begin
            exp_out   = ta + tb_ + tc;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        check({tag, "_out"}, int'(out), exp_out);
        check({tag, "_vld"}, int'(out_valid), exp_valid);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        in_valid8 = 1'b0;
        a8        = '0;
        b8        = '0;
        cin8      = 1'b0;
        in_valid1 = 1'b0;
        a1        = '0;
        b1        = '0;
        cin1      = 1'b0;

        #12;
        check("reset_out", int'(out), 0);
        check("reset_vld", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // corners, cin=0
        step(0, 0, 0, 1, "c_0p0");
        step(31, 0, 0, 1, "c_31p0");
        step(0, 31, 0, 1, "c_0p31");
        step(31, 31, 0, 1, "c_31p31");
        step(16, 16, 0, 1, "c_16p16");

        // carry-in
        step(31, 31, 1, 1, "ci_31p31");
        step(0, 0, 1, 1, "ci_0p0");
        step(15, 16, 1, 1, "ci_15p16");

        // async reset with a valid result pending
        step(9, 10, 0, 1, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        exp_out   = 0;
        exp_valid = 0;
        check("async_rst_out", int'(out), 0);
        check("async_rst_vld", int'(out_valid), 0);
        a        = 5'd9;
        b        = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_out", int'(out), 0);
        check("rst_drop_vld", int'(out_valid), 0);
        #2;
        rst = 1'b0;
        step(3, 4, 0, 1, "post_rst");

        // valid gaps with random don't-care operands while idle
        step(5, 6, 0, 1, "gap_first");
        for (int i = 0; i < 3; i++)
            step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 1)), 0, "gap_idle");
        step(2, 2, 0, 1, "gap_second");

        // exhaustive sweep, back-to-back
        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                step(ia, ib, 0, 1, "sweep");
                $display("%03d+%03d=%03d", ia, ib, out);
            end
        end

        // random traffic with random gaps and carry-in
        for (int i = 0; i < 300; i++)
            step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
                 "rand");

        // other widths
        a8        = 8'd255;
        b8        = 8'd255;
        cin8      = 1'b1;
        in_valid8 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b1;
        cin1      = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid1 = 1'b0;
        check("w8_out", int'(out8), 511);
        check("w8_vld", int'(out_valid8), 1);
        check("w1_out", int'(out1), 3);
        check("w1_vld", int'(out_valid1), 1);
        @(posedge clk);
        #1;
        check("w8_hold", int'(out8), 511);
        check("w8_idle", int'(out_valid8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
